// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STALL
  } meas_state_t;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser plus history flop.
// Gives the synchronised level and its rise/fall strobes.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic i_async,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_s    = r_sync[STAGES-1];
  assign o_rise = o_s & ~r_hist;
  assign o_fall = ~o_s & r_hist;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of an async divided clock
// in clk_in cycles, with stall detect and valid/ready output.
module clock_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  // Longest legal interval keeps period+1 from wrapping.
  localparam logic [CNT_W-1:0] STALL_CNT = ~ONE;

  logic w_s;
  logic w_rise;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in  (clk_in),
    .reset   (reset),
    .i_async (sig_in),
    .o_s     (w_s),
    .o_rise  (w_rise),
    .o_fall  ()
  );

  meas_state_t      r_state;
  meas_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_hcnt_inc;
  logic             w_done;
  logic             w_stall_set;
  logic             w_stall_clr;
  logic             w_hs;

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_overrun;
  logic             r_stalled;

  assign w_cnt_inc  = r_cnt + ONE;
  assign w_hcnt_inc = r_hcnt + {{(CNT_W-1){1'b0}}, w_s};
  assign w_hs       = r_valid & meas_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hcnt_nxt  = r_hcnt;
    w_done      = 1'b0;
    w_stall_set = 1'b0;
    w_stall_clr = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = '0;
          w_hcnt_nxt  = '0;
        end
      end
      MEASURE: begin
        if (w_rise) begin
          w_done     = 1'b1;
          w_cnt_nxt  = '0;
          w_hcnt_nxt = '0;
        end else begin
          w_cnt_nxt  = w_cnt_inc;
          w_hcnt_nxt = w_hcnt_inc;
          if (w_cnt_inc == STALL_CNT) begin
            w_state_nxt = STALL;
            w_stall_set = 1'b1;
          end
        end
      end
      STALL: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = '0;
          w_hcnt_nxt  = '0;
          w_stall_clr = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_stalled <= 1'b0;
    end else begin
      if (w_done && (!r_valid || meas_ready)) begin
        r_period <= w_cnt_inc;
        r_high   <= w_hcnt_inc;
        r_valid  <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
      if (w_hs) begin
        r_overrun <= 1'b0;
      end else if (w_done && r_valid) begin
        r_overrun <= 1'b1;
      end
      if (w_stall_set) begin
        r_stalled <= 1'b1;
      end else if (w_stall_clr) begin
        r_stalled <= 1'b0;
      end
    end
  end

  assign period     = r_period;
  assign high_time  = r_high;
  assign meas_valid = r_valid;
  assign overrun    = r_overrun;
  assign stalled    = r_stalled;

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter (CNT_W=8).
// Stimulus pushes expected results; a monitor pops on handshake.
module tb_clock_period_meter;

  localparam int W = 8;

  logic         clk_in;
  logic         reset;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         meas_ready;
  logic         overrun;
  logic         stalled;

  clock_period_meter #(
    .CNT_W       (W),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .overrun    (overrun),
    .stalled    (stalled)
  );

  typedef struct {
    int p;
    int h;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   vcnt = 0;
  int   last_rise = 0;
  bit   gen_on = 0;
  int   hi_len = 8;
  int   lo_len = 8;
  int   ph = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic push(input int n, input int p, input int h);
    exp_t e;
    e.p = p;
    e.h = h;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // sig_in pattern: high for hi_len, low for lo_len clk_in cycles
  initial begin
    logic nv;
    sig_in = 1'b0;
    forever begin
      @(posedge clk_in);
      #2;
      if (gen_on) begin
        nv = (ph < hi_len);
        if (nv && !sig_in) last_rise = cyc;
        sig_in = nv;
        ph = (ph + 1) % (hi_len + lo_len);
      end else begin
        sig_in = 1'b0;
        ph = 0;
      end
    end
  end

  always @(negedge clk_in) begin
    if (reset && meas_valid) vcnt++;
    if (reset && meas_valid && meas_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("period", int'(period), e.p);
        chk("high_time", int'(high_time), e.h);
      end
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk_in);
      n++;
    end
    chk("drain_left", q.size(), 0);
    gen_on = 0;
  endtask

  task automatic do_reset();
    gen_on = 0;
    @(posedge clk_in);
    #3 reset = 1'b0;
    #1;
    chk("rst_outs", int'({period, high_time, meas_valid,
                          overrun, stalled}), 0);
    repeat (2) @(posedge clk_in);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk_in);
  endtask

  task automatic wait_sig(input string nm, input int which,
                          input int val, input int budget);
    int n = 0;
    bit hit = 0;
    while (!hit && n < budget) begin
      @(posedge clk_in);
      #1;
      n++;
      case (which)
        0: hit = (meas_valid == val[0]);
        1: hit = (overrun == val[0]);
        default: hit = (stalled == val[0]);
      endcase
    end
    chk(nm, int'(hit), 1);
  endtask

  initial begin
    int k0;
    bit bad;
    reset = 1'b0;
    meas_ready = 1'b0;
    #1;
    chk("por_outs", int'({period, high_time, meas_valid,
                          overrun, stalled}), 0);
    repeat (3) @(posedge clk_in);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk_in);

    // 1: toggle every 8 cycles
    meas_ready = 1'b1;
    hi_len = 8;
    lo_len = 8;
    push(4, 16, 8);
    gen_on = 1;
    drain(200);
    chk("t1_overrun", int'(overrun), 0);
    do_reset();

    // 2: high 3 / low 7, one-cycle valid pulses
    hi_len = 3;
    lo_len = 7;
    vcnt = 0;
    push(4, 10, 3);
    gen_on = 1;
    drain(200);
    repeat (3) @(posedge clk_in);
    chk("t2_valid_cycles", vcnt, 4);
    do_reset();

    // 3: consumer stalled 40 cycles
    meas_ready = 1'b0;
    hi_len = 8;
    lo_len = 8;
    push(1, 16, 8);
    gen_on = 1;
    wait_sig("t3_first_valid", 0, 1, 100);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in);
      #1;
      if (period != 8'd16 || high_time != 8'd8 || !meas_valid) bad = 1;
    end
    chk("t3_held_stable", int'(bad), 0);
    chk("t3_overrun_set", int'(overrun), 1);
    meas_ready = 1'b1;
    gen_on = 0;
    @(posedge clk_in);
    #1;
    chk("t3_overrun_clr", int'(overrun), 0);
    chk("t3_valid_clr", int'(meas_valid), 0);
    chk("t3_accepted", q.size(), 0);
    do_reset();

    // 6: completion coincident with handshake
    meas_ready = 1'b0;
    push(2, 16, 8);
    gen_on = 1;
    wait_sig("t6_first_valid", 0, 1, 100);
    repeat (15) @(posedge clk_in);
    #2 meas_ready = 1'b1;
    @(posedge clk_in);
    #1;
    chk("t6_valid_kept", int'(meas_valid), 1);
    chk("t6_no_overrun", int'(overrun), 0);
    @(posedge clk_in);
    #1;
    gen_on = 0;
    chk("t6_valid_drop", int'(meas_valid), 0);
    drain(5);
    do_reset();

    // 4: stall detection, 254 cycles after detected rise (+3 sync)
    meas_ready = 1'b1;
    push(2, 16, 8);
    gen_on = 1;
    drain(200);
    wait_sig("t4_stall_seen", 2, 1, 400);
    chk("t4_stall_delay", cyc - last_rise, 257);
    gen_on = 1;
    push(2, 16, 8);
    wait_sig("t4_stall_clr_seen", 2, 0, 20);
    chk("t4_stall_clr_delay", cyc - last_rise, 3);
    drain(200);
    do_reset();

    // 5: async reset mid-measurement, then two rises needed
    meas_ready = 1'b0;
    gen_on = 1;
    wait_sig("t5_overrun_seen", 1, 1, 100);
    chk("t5_valid_before", int'(meas_valid), 1);
    do_reset();
    meas_ready = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    k0 = cyc;
    push(2, 16, 8);
    gen_on = 1;
    wait_sig("t5_valid_seen", 0, 1, 100);
    chk("t5_first_result_at", cyc - k0, 19);
    drain(200);

    repeat (5) @(posedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
